// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer
//   Initiator side of the ALU operand/opcode interface. It takes one command at a time
//   over a valid/ready channel and answers illegal opcodes directly with an error
//   response. Legal commands drive registered operands into the combinational ALU.
//   Those operands are held for SETTLE_CYC cycles, then alu_out is captured and
//   returned as a single response. The response channel honours backpressure.
//
// Ports
//   clk, rst_n            clock (rising edge) and asynchronous active-low reset
//   cmd_valid/cmd_ready   command handshake; cmd_ready is high only while idle
//   cmd_op, cmd_a, cmd_b  opcode and operands of the offered command
//   alu_op, alu_inA/inB   registered opcode and operands driven to the ALU
//   alu_out               combinational ALU result
//   rsp_valid/rsp_ready   response handshake
//   rsp_data, rsp_zero    captured result and its zero flag
//   rsp_err               response belongs to an illegal opcode
//   issued_cnt, err_cnt   saturating counts of issued and rejected commands
module alu_cmd_sequencer #(
  parameter int unsigned N          = 32,
  parameter int unsigned SETTLE_CYC = 1,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [3:0]       cmd_op,
  input  logic [N-1:0]     cmd_a,
  input  logic [N-1:0]     cmd_b,
  output logic [3:0]       alu_op,
  output logic [N-1:0]     alu_inA,
  output logic [N-1:0]     alu_inB,
  input  logic [N-1:0]     alu_out,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [N-1:0]     rsp_data,
  output logic             rsp_zero,
  output logic             rsp_err,
  output logic [CNT_W-1:0] issued_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  // Settle counter holds SETTLE_CYC down to 1.
  localparam int unsigned SettleW = $clog2(SETTLE_CYC + 1);
  localparam logic [SettleW-1:0] SettleLoad = SettleW'(SETTLE_CYC);
  localparam logic [SettleW-1:0] SettleOne  = SettleW'(1);
  localparam logic [CNT_W-1:0]   CntOne     = CNT_W'(1);
  localparam logic [CNT_W-1:0]   CntMax     = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    StIdle,
    StSettle,
    StResp
  } state_e;

  state_e               state_q;
  logic [SettleW-1:0]   settle_q;
  logic                 op_legal;

  always_comb begin
    op_legal = 1'b0;
    case (cmd_op)
      4'd0, 4'd1, 4'd2, 4'd6, 4'd7, 4'd12, 4'd13: op_legal = 1'b1;
      default:                                    op_legal = 1'b0;
    endcase
  end

  assign cmd_ready = (state_q == StIdle);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      settle_q   <= '0;
      alu_op     <= '0;
      alu_inA    <= '0;
      alu_inB    <= '0;
      rsp_valid  <= 1'b0;
      rsp_data   <= '0;
      rsp_zero   <= 1'b0;
      rsp_err    <= 1'b0;
      issued_cnt <= '0;
      err_cnt    <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (cmd_valid) begin
            if (op_legal) begin
              alu_op   <= cmd_op;
              alu_inA  <= cmd_a;
              alu_inB  <= cmd_b;
              settle_q <= SettleLoad;
              if (issued_cnt != CntMax) begin
                issued_cnt <= issued_cnt + CntOne;
              end
              state_q  <= StSettle;
            end else begin
              // Illegal opcode never reaches the ALU; answer straight away.
              rsp_err   <= 1'b1;
              rsp_data  <= '0;
              rsp_zero  <= 1'b0;
              rsp_valid <= 1'b1;
              if (err_cnt != CntMax) begin
                err_cnt <= err_cnt + CntOne;
              end
              state_q   <= StResp;
            end
          end
        end

        StSettle: begin
          settle_q <= settle_q - SettleOne;
          if (settle_q == SettleOne) begin
            rsp_data  <= alu_out;
            rsp_zero  <= (alu_out == '0);
            rsp_err   <= 1'b0;
            rsp_valid <= 1'b1;
            state_q   <= StResp;
          end
        end

        StResp: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state_q   <= StIdle;
          end
        end

        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  // Response payload must not move while the consumer stalls.
  property p_rsp_stable;
    @(posedge clk) disable iff (!rst_n)
      (rsp_valid && !rsp_ready) |=>
        (rsp_valid && $stable(rsp_data) && $stable(rsp_zero) && $stable(rsp_err));
  endproperty
  a_rsp_stable: assert property (p_rsp_stable);

  // ALU inputs only change on a legal accept.
  property p_alu_hold;
    @(posedge clk) disable iff (!rst_n)
      !(cmd_valid && cmd_ready && op_legal) |=>
        ($stable(alu_op) && $stable(alu_inA) && $stable(alu_inB));
  endproperty
  a_alu_hold: assert property (p_alu_hold);

  // Commands and responses never overlap.
  property p_no_overlap;
    @(posedge clk) disable iff (!rst_n)
      cmd_ready |-> !rsp_valid;
  endproperty
  a_no_overlap: assert property (p_no_overlap);

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed bench for alu_cmd_sequencer with a behavioural ALU stand-in.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_alu_cmd_sequencer;

  localparam int unsigned N  = 32;
  localparam int unsigned S  = 2;
  localparam int unsigned CW = 2;

  logic          clk;
  logic          rst_n;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [3:0]    cmd_op;
  logic [N-1:0]  cmd_a;
  logic [N-1:0]  cmd_b;
  logic [3:0]    alu_op;
  logic [N-1:0]  alu_inA;
  logic [N-1:0]  alu_inB;
  logic [N-1:0]  alu_out;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [N-1:0]  rsp_data;
  logic          rsp_zero;
  logic          rsp_err;
  logic [CW-1:0] issued_cnt;
  logic [CW-1:0] err_cnt;

  int checks   = 0;
  int failures = 0;

  alu_cmd_sequencer #(
    .N          (N),
    .SETTLE_CYC (S),
    .CNT_W      (CW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_a      (cmd_a),
    .cmd_b      (cmd_b),
    .alu_op     (alu_op),
    .alu_inA    (alu_inA),
    .alu_inB    (alu_inB),
    .alu_out    (alu_out),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .rsp_zero   (rsp_zero),
    .rsp_err    (rsp_err),
    .issued_cnt (issued_cnt),
    .err_cnt    (err_cnt)
  );

  // ALU stand-in; PACK joins the low halves of A and B.
  always_comb begin
    alu_out = '0;
    case (alu_op)
      4'd0:    alu_out = alu_inA & alu_inB;
      4'd1:    alu_out = alu_inA | alu_inB;
      4'd2:    alu_out = alu_inA + alu_inB;
      4'd6:    alu_out = alu_inA - alu_inB;
      4'd7:    alu_out = ($signed(alu_inA) < $signed(alu_inB)) ? 32'd1 : 32'd0;
      4'd12:   alu_out = ~(alu_inA | alu_inB);
      4'd13:   alu_out = {alu_inA[15:0], alu_inB[15:0]};
      default: alu_out = '0;
    endcase
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Offer one command from a falling edge while idle; lat counts falling edges
  // after the accepting rising edge up to and including the first with rsp_valid.
  task automatic issue(input logic [3:0] op, input logic [N-1:0] a, input logic [N-1:0] b,
                       output int lat);
    cmd_op    = op;
    cmd_a     = a;
    cmd_b     = b;
    cmd_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    lat = 1;
    while (rsp_valid !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    rsp_ready = 1'b0;
    cmd_op    = 4'd0;
    cmd_a     = '0;
    cmd_b     = '0;
    repeat (2) @(negedge clk);
    checks++;
    if ({alu_op, alu_inA, alu_inB} !== '0) begin
      failures++;
      $display("FAIL reset_alu got=%0h/%0h/%0h exp=0", alu_op, alu_inA, alu_inB);
    end
    checks++;
    if ({rsp_valid, rsp_data, rsp_zero, rsp_err} !== '0) begin
      failures++;
      $display("FAIL reset_rsp got v=%0b d=%0h z=%0b e=%0b exp=0", rsp_valid, rsp_data,
               rsp_zero, rsp_err);
    end
    checks++;
    if ({issued_cnt, err_cnt} !== '0) begin
      failures++;
      $display("FAIL reset_cnt got=%0d/%0d exp=0/0", issued_cnt, err_cnt);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_ready got=%0b exp=1", cmd_ready);
    end
  endtask

  task automatic test_add();
    int lat;
    rsp_ready = 1'b1;
    issue(4'd2, 32'd5, 32'd3, lat);
    checks++;
    if (lat !== 3) begin
      failures++;
      $display("FAIL add_latency got=%0d exp=3", lat);
    end
    checks++;
    if ({rsp_data, rsp_zero, rsp_err} !== {32'd8, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL add_rsp got d=%0h z=%0b e=%0b exp d=8 z=0 e=0", rsp_data, rsp_zero,
               rsp_err);
    end
    checks++;
    if (issued_cnt !== 2'd1) begin
      failures++;
      $display("FAIL add_issued got=%0d exp=1", issued_cnt);
    end
    @(negedge clk);
    checks++;
    if ({rsp_valid, cmd_ready} !== 2'b01) begin
      failures++;
      $display("FAIL add_return_idle got v=%0b r=%0b exp v=0 r=1", rsp_valid, cmd_ready);
    end
  endtask

  task automatic test_illegal();
    int lat;
    issue(4'd3, 32'd1, 32'd1, lat);
    checks++;
    if (lat !== 1) begin
      failures++;
      $display("FAIL illegal_latency got=%0d exp=1", lat);
    end
    checks++;
    if ({rsp_err, rsp_data, rsp_zero} !== {1'b1, 32'd0, 1'b0}) begin
      failures++;
      $display("FAIL illegal_rsp got e=%0b d=%0h z=%0b exp e=1 d=0 z=0", rsp_err, rsp_data,
               rsp_zero);
    end
    checks++;
    if ({err_cnt, issued_cnt} !== {2'd1, 2'd1}) begin
      failures++;
      $display("FAIL illegal_cnt got err=%0d iss=%0d exp 1/1", err_cnt, issued_cnt);
    end
    checks++;
    if ({alu_op, alu_inA, alu_inB} !== {4'd2, 32'd5, 32'd3}) begin
      failures++;
      $display("FAIL illegal_alu_held got=%0h/%0h/%0h exp=2/5/3", alu_op, alu_inA, alu_inB);
    end
    @(negedge clk);
    issue(4'd14, 32'd0, 32'd0, lat);
    checks++;
    if ({lat, rsp_err, err_cnt} !== {32'd1, 1'b1, 2'd2}) begin
      failures++;
      $display("FAIL illegal_op14 got lat=%0d e=%0b cnt=%0d exp 1/1/2", lat, rsp_err, err_cnt);
    end
    @(negedge clk);
  endtask

  task automatic test_zero_flag();
    int lat;
    issue(4'd6, 32'd7, 32'd7, lat);
    checks++;
    if ({lat, rsp_data, rsp_zero, rsp_err} !== {32'd3, 32'd0, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL sub_zero got lat=%0d d=%0h z=%0b e=%0b exp 3/0/1/0", lat, rsp_data,
               rsp_zero, rsp_err);
    end
    @(negedge clk);
    issue(4'd7, 32'd2, 32'd9, lat);
    checks++;
    if ({rsp_data, rsp_zero} !== {32'd1, 1'b0}) begin
      failures++;
      $display("FAIL slt got d=%0h z=%0b exp d=1 z=0", rsp_data, rsp_zero);
    end
    @(negedge clk);
    issue(4'd12, 32'd0, 32'd0, lat);
    checks++;
    if ({rsp_data, rsp_zero} !== {32'hffff_ffff, 1'b0}) begin
      failures++;
      $display("FAIL nor got d=%0h z=%0b exp d=ffffffff z=0", rsp_data, rsp_zero);
    end
    @(negedge clk);
    issue(4'd13, 32'h1234_5678, 32'h9abc_def0, lat);
    checks++;
    if ({rsp_data, rsp_err} !== {32'h5678_def0, 1'b0}) begin
      failures++;
      $display("FAIL pack got d=%0h e=%0b exp d=5678def0 e=0", rsp_data, rsp_err);
    end
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    int lat;
    do_reset();
    rsp_ready = 1'b0;
    issue(4'd0, 32'h0000_f0f0, 32'h0000_ff00, lat);
    checks++;
    if ({lat, rsp_data} !== {32'd3, 32'h0000_f000}) begin
      failures++;
      $display("FAIL bp_and got lat=%0d d=%0h exp 3/f000", lat, rsp_data);
    end
    for (int i = 0; i < 5; i++) begin
      cmd_valid = 1'b1;
      cmd_op    = 4'd2;
      cmd_a     = 32'h0000_dead;
      cmd_b     = 32'h0000_beef;
      @(negedge clk);
      checks++;
      if ({rsp_valid, cmd_ready, rsp_data, alu_inA, issued_cnt}
          !== {1'b1, 1'b0, 32'h0000_f000, 32'h0000_f0f0, 2'd1}) begin
        failures++;
        $display("FAIL bp_hold cyc=%0d got v=%0b r=%0b d=%0h a=%0h n=%0d exp 1/0/f000/f0f0/1",
                 i, rsp_valid, cmd_ready, rsp_data, alu_inA, issued_cnt);
      end
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    checks++;
    if ({rsp_valid, cmd_ready} !== 2'b01) begin
      failures++;
      $display("FAIL bp_release got v=%0b r=%0b exp v=0 r=1", rsp_valid, cmd_ready);
    end
  endtask

  task automatic test_reset_mid_settle();
    int lat;
    int seen;
    do_reset();
    rsp_ready = 1'b1;
    cmd_op    = 4'd2;
    cmd_a     = 32'd10;
    cmd_b     = 32'd20;
    cmd_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({alu_op, alu_inA, alu_inB, issued_cnt, rsp_valid, cmd_ready}
        !== {4'd0, 32'd0, 32'd0, 2'd0, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL midrst_clear got op=%0h a=%0h b=%0h n=%0d v=%0b r=%0b exp 0/0/0/0/0/1",
               alu_op, alu_inA, alu_inB, issued_cnt, rsp_valid, cmd_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (rsp_valid === 1'b1) seen++;
    end
    checks++;
    if (seen !== 0) begin
      failures++;
      $display("FAIL midrst_no_rsp got=%0d exp=0", seen);
    end
    issue(4'd2, 32'd10, 32'd20, lat);
    checks++;
    if ({lat, rsp_data, issued_cnt} !== {32'd3, 32'd30, 2'd1}) begin
      failures++;
      $display("FAIL midrst_next got lat=%0d d=%0h n=%0d exp 3/1e/1", lat, rsp_data,
               issued_cnt);
    end
    @(negedge clk);
  endtask

  task automatic test_saturate();
    int lat;
    do_reset();
    rsp_ready = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      issue(4'd2, 32'(i * 100), 32'(i), lat);
      @(negedge clk);
      checks++;
      if ({32'(issued_cnt), rsp_data} !== {32'((i < 3) ? i : 3), 32'(i * 101)}) begin
        failures++;
        $display("FAIL sat_issued i=%0d got n=%0d d=%0d exp n=%0d d=%0d", i, issued_cnt,
                 rsp_data, (i < 3) ? i : 3, i * 101);
      end
    end
    for (int j = 1; j <= 4; j++) begin
      issue(4'(j + 7), 32'd0, 32'd0, lat);
      @(negedge clk);
      checks++;
      if ({32'(err_cnt), 32'(issued_cnt)} !== {32'((j < 3) ? j : 3), 32'd3}) begin
        failures++;
        $display("FAIL sat_err j=%0d got e=%0d n=%0d exp e=%0d n=3", j, err_cnt, issued_cnt,
                 (j < 3) ? j : 3);
      end
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    do_reset();
    rsp_ready = 1'b1;
    issue(4'd0, 32'hff00_ff00, 32'h0f0f_0f0f, lat);
    @(negedge clk);
    checks++;
    if (rsp_data !== 32'h0f00_0f00) begin
      failures++;
      $display("FAIL b2b_and got=%0h exp=0f000f00", rsp_data);
    end
    issue(4'd9, 32'd1, 32'd2, lat);
    @(negedge clk);
    issue(4'd1, 32'hff00_0000, 32'h0000_00ff, lat);
    checks++;
    if ({lat, rsp_data, rsp_err, alu_op} !== {32'd3, 32'hff00_00ff, 1'b0, 4'd1}) begin
      failures++;
      $display("FAIL b2b_or got lat=%0d d=%0h e=%0b op=%0h exp 3/ff0000ff/0/1", lat, rsp_data,
               rsp_err, alu_op);
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_add();
    test_illegal();
    test_zero_flag();
    test_backpressure();
    test_reset_mid_settle();
    test_saturate();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
